// File: rtl/ddr3_loopback_traffic_generator_pkg.sv
// rtl/ddr3_loopback_traffic_generator_pkg.sv - shared states, LFSR taps and pattern seed for the loopback test
package ddr3_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Fibonacci feedback masks (bit n set = stage n+1 tapped), maximal length
  localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;

  localparam logic [31:0] PATTERN_SEED = 32'h1;

  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      8:       return 32'(LFSR_TAPS_8);
      default: return 32'(LFSR_TAPS_16);
    endcase
  endfunction

endpackage

// File: rtl/ddr3_loopback_traffic_generator_if.sv
// rtl/ddr3_loopback_traffic_generator_if.sv - user-side request/response bus between the test generator and the controller
interface ddr3_loopback_traffic_generator_if #(
  parameter int ADDR_BITWIDTH = 18,
  parameter int DQ_BITWIDTH   = 16
);
  logic                     write_enable;
  logic                     read_enable;
  logic [ADDR_BITWIDTH-1:0] i_user_data_address;
  logic [DQ_BITWIDTH-1:0]   data_to_ram;
  logic                     write_accepted;
  logic [DQ_BITWIDTH-1:0]   data_from_ram;
  logic                     read_data_valid;

  modport master (
    output write_enable, read_enable, i_user_data_address, data_to_ram,
    input  write_accepted, data_from_ram, read_data_valid
  );

  modport slave (
    input  write_enable, read_enable, i_user_data_address, data_to_ram,
    output write_accepted, data_from_ram, read_data_valid
  );
endinterface

// File: rtl/ddr3_pattern_gen.sv
// rtl/ddr3_pattern_gen.sv - test word sequence source, incrementing or LFSR (macro LFSR_PATTERN_EN)
// Output holds pattern(k) after a reseed followed by k steps; cleared to zero by reset.
module ddr3_pattern_gen
  import ddr3_test_pkg::*;
#(
  parameter int DQ_BITWIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_reseed,
  input  logic                   i_step,
  output logic [DQ_BITWIDTH-1:0] o_pattern
);

  logic [DQ_BITWIDTH-1:0] r_pattern;
  logic [DQ_BITWIDTH-1:0] w_next_pattern;

`ifdef LFSR_PATTERN_EN
  localparam logic [DQ_BITWIDTH-1:0] TAPS = DQ_BITWIDTH'(lfsr_taps(DQ_BITWIDTH));
  assign w_next_pattern = {r_pattern[DQ_BITWIDTH-2:0], ^(r_pattern & TAPS)};
`else
  assign w_next_pattern = r_pattern + DQ_BITWIDTH'(1);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pattern <= '0;
    end else if (i_reseed) begin
      r_pattern <= DQ_BITWIDTH'(PATTERN_SEED);
    end else if (i_step) begin
      r_pattern <= w_next_pattern;
    end
  end

  assign o_pattern = r_pattern;

endmodule

// File: rtl/ddr3_loopback_traffic_generator.sv
// rtl/ddr3_loopback_traffic_generator.sv - writes a pattern window to RAM, reads it back and reports pass/errors
// Data pattern selectable with macro LFSR_PATTERN_EN (inside ddr3_pattern_gen).
module ddr3_loopback_traffic_generator
  import ddr3_test_pkg::*;
#(
  parameter int ADDRESS_BITWIDTH      = 15,
  parameter int BANK_ADDRESS_BITWIDTH = 3,
  parameter int DQ_BITWIDTH           = 16,
  parameter int NUM_OF_TEST_DATA      = 4,
  parameter int START_ADDRESS         = 0,
  parameter int READ_TIMEOUT          = 4095
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              start,
  ddr3_loopback_traffic_generator_if.master                 bus,
  output logic                                              busy,
  output logic                                              done,
  output logic                                              pass,
  output logic [$clog2(NUM_OF_TEST_DATA+1)-1:0]             error_count,
  output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] first_error_address,
  output logic                                              timeout
);

  localparam int AW    = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;
  localparam int ECW   = $clog2(NUM_OF_TEST_DATA + 1);
  localparam int IDX_W = $clog2(NUM_OF_TEST_DATA + 1);
  localparam int CNT_W = $clog2(READ_TIMEOUT + 1);

  localparam logic [AW-1:0]    START_ADDR   = AW'(START_ADDRESS);
  localparam logic [IDX_W-1:0] LAST_INDEX   = IDX_W'(NUM_OF_TEST_DATA - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(READ_TIMEOUT - 1);

  state_t           r_state, w_nxt_state;
  logic [IDX_W-1:0] r_index, w_nxt_index;
  logic [AW-1:0]    r_address, w_nxt_address;
  logic [ECW-1:0]   r_error_count, w_nxt_error_count;
  logic [AW-1:0]    r_first_error_address, w_nxt_first_error_address;
  logic             r_pass, w_nxt_pass;
  logic             r_timeout, w_nxt_timeout;
  logic [CNT_W-1:0] r_wait_count, w_nxt_wait_count;

  logic                   w_wr_reseed, w_wr_step;
  logic                   w_rd_reseed, w_rd_step;
  logic [DQ_BITWIDTH-1:0] w_wr_pattern, w_rd_pattern;
  logic                   w_last;

  ddr3_pattern_gen #(.DQ_BITWIDTH(DQ_BITWIDTH)) u_wr_pattern (
    .clk       (clk),
    .reset     (reset),
    .i_reseed  (w_wr_reseed),
    .i_step    (w_wr_step),
    .o_pattern (w_wr_pattern)
  );

  ddr3_pattern_gen #(.DQ_BITWIDTH(DQ_BITWIDTH)) u_rd_pattern (
    .clk       (clk),
    .reset     (reset),
    .i_reseed  (w_rd_reseed),
    .i_step    (w_rd_step),
    .o_pattern (w_rd_pattern)
  );

  assign w_last = (r_index == LAST_INDEX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state               <= ST_IDLE;
      r_index               <= '0;
      r_address             <= '0;
      r_error_count         <= '0;
      r_first_error_address <= '0;
      r_pass                <= 1'b0;
      r_timeout             <= 1'b0;
      r_wait_count          <= '0;
    end else begin
      r_state               <= w_nxt_state;
      r_index               <= w_nxt_index;
      r_address             <= w_nxt_address;
      r_error_count         <= w_nxt_error_count;
      r_first_error_address <= w_nxt_first_error_address;
      r_pass                <= w_nxt_pass;
      r_timeout             <= w_nxt_timeout;
      r_wait_count          <= w_nxt_wait_count;
    end
  end

  always_comb begin
    w_nxt_state               = r_state;
    w_nxt_index               = r_index;
    w_nxt_address             = r_address;
    w_nxt_error_count         = r_error_count;
    w_nxt_first_error_address = r_first_error_address;
    w_nxt_pass                = r_pass;
    w_nxt_timeout             = r_timeout;
    w_nxt_wait_count          = r_wait_count;
    w_wr_reseed               = 1'b0;
    w_wr_step                 = 1'b0;
    w_rd_reseed               = 1'b0;
    w_rd_step                 = 1'b0;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_nxt_state               = ST_WRITE;
          w_nxt_index               = '0;
          w_nxt_address             = START_ADDR;
          w_nxt_error_count         = '0;
          w_nxt_first_error_address = '0;
          w_nxt_pass                = 1'b0;
          w_nxt_timeout             = 1'b0;
          w_wr_reseed               = 1'b1;
        end
      end

      ST_WRITE: begin
        if (bus.write_accepted) begin
          w_wr_step = 1'b1;
          if (w_last) begin
            w_nxt_state      = ST_READ;
            w_nxt_index      = '0;
            w_nxt_address    = START_ADDR;
            w_nxt_wait_count = '0;
            w_rd_reseed      = 1'b1;
          end else begin
            w_nxt_index   = r_index + IDX_W'(1);
            w_nxt_address = r_address + AW'(1);
          end
        end
      end

      ST_READ: begin
        if (bus.read_data_valid) begin
          w_rd_step        = 1'b1;
          w_nxt_wait_count = '0;
          if (bus.data_from_ram != w_rd_pattern) begin
            if (r_error_count != '1) begin
              w_nxt_error_count = r_error_count + ECW'(1);
            end
            if (r_error_count == '0) begin
              w_nxt_first_error_address = r_address;
            end
          end
          if (w_last) begin
            w_nxt_state = ST_DONE;
            w_nxt_pass  = (w_nxt_error_count == '0);
          end else begin
            w_nxt_index   = r_index + IDX_W'(1);
            w_nxt_address = r_address + AW'(1);
          end
        end else if (r_wait_count == TIMEOUT_LAST) begin
          // Last permitted waiting cycle expired: abandon the run at this address
          w_nxt_timeout = 1'b1;
          w_nxt_pass    = 1'b0;
          w_nxt_state   = ST_DONE;
          if (r_error_count == '0) begin
            w_nxt_first_error_address = r_address;
          end
        end else begin
          w_nxt_wait_count = r_wait_count + CNT_W'(1);
        end
      end

      default: begin
        w_nxt_state = ST_IDLE;
      end
    endcase
  end

  assign bus.write_enable        = (r_state == ST_WRITE);
  assign bus.read_enable         = (r_state == ST_READ);
  assign bus.i_user_data_address = r_address;
  assign bus.data_to_ram         = w_wr_pattern;

  assign busy                = (r_state == ST_WRITE) || (r_state == ST_READ);
  assign done                = (r_state == ST_DONE);
  assign pass                = r_pass;
  assign error_count         = r_error_count;
  assign first_error_address = r_first_error_address;
  assign timeout             = r_timeout;

endmodule

// File: tb/tb_ddr3_loopback_traffic_generator.sv
// tb/tb_ddr3_loopback_traffic_generator.sv - randomized controller model and scoreboard for the loopback generator
module tb_ddr3_loopback_traffic_generator;

  localparam int AB    = 15;
  localparam int BB    = 3;
  localparam int DQ    = 16;
  localparam int NUM   = 4;
  localparam int START = 0;
  localparam int RTO   = 15;
  localparam int AW    = AB + BB;
  localparam int ECW   = $clog2(NUM + 1);

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy, done, pass, timeout;
  logic [ECW-1:0] error_count;
  logic [AW-1:0]  first_error_address;

  int n_cmp = 0;
  int n_bad = 0;

  ddr3_loopback_traffic_generator_if #(.ADDR_BITWIDTH(AW), .DQ_BITWIDTH(DQ)) bus ();

  ddr3_loopback_traffic_generator #(
    .ADDRESS_BITWIDTH      (AB),
    .BANK_ADDRESS_BITWIDTH (BB),
    .DQ_BITWIDTH           (DQ),
    .NUM_OF_TEST_DATA      (NUM),
    .START_ADDRESS         (START),
    .READ_TIMEOUT          (RTO)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .bus                 (bus.master),
    .busy                (busy),
    .done                (done),
    .pass                (pass),
    .error_count         (error_count),
    .first_error_address (first_error_address),
    .timeout             (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DQ-1:0] data;
  } wr_t;

  wr_t           exp_wr_q[$];
  logic [AW-1:0] exp_rd_q[$];

  function automatic logic [DQ-1:0] pat(input int i);
    return DQ'(i + 1);
  endfunction

  function automatic logic [AW-1:0] adr(input int i);
    return AW'(START + i);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every request the DUT presents must match the head of the expected stream
  always @(negedge clk) begin
    if (!reset) begin
      check("enables_exclusive", 32'(bus.write_enable & bus.read_enable), 0);
      if (bus.write_enable) begin
        check("wr_pending", 32'(exp_wr_q.size() != 0), 1);
        if (exp_wr_q.size() != 0) begin
          check("wr_addr", 32'(bus.i_user_data_address), 32'(exp_wr_q[0].addr));
          check("wr_data", 32'(bus.data_to_ram), 32'(exp_wr_q[0].data));
          if (bus.write_accepted) void'(exp_wr_q.pop_front());
        end
      end
      if (bus.read_enable) begin
        check("rd_pending", 32'(exp_rd_q.size() != 0), 1);
        if (exp_rd_q.size() != 0) begin
          check("rd_addr", 32'(bus.i_user_data_address), 32'(exp_rd_q[0]));
          if (bus.read_data_valid) void'(exp_rd_q.pop_front());
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick();
    check("rst_we", 32'(bus.write_enable), 0);
    check("rst_re", 32'(bus.read_enable), 0);
    check("rst_addr", 32'(bus.i_user_data_address), 0);
    check("rst_data", 32'(bus.data_to_ram), 0);
    check("rst_status", 32'({busy, done, pass, timeout}), 0);
    check("rst_ec", 32'(error_count), 0);
    check("rst_fea", 32'(first_error_address), 0);
    reset = 1'b0;
    tick();
  endtask

  task automatic run(input logic [NUM-1:0] bad_mask, input bit withhold, input bit spur,
                     input bit fixed_bad, input bit pins);
    int            exp_err;
    logic [AW-1:0] exp_first;
    logic [DQ-1:0] rdata;
    int            d;
    int            cnt;
    int            lit_data [4] = '{1, 2, 3, 4};
    exp_err   = 0;
    exp_first = '0;
    exp_wr_q.delete();
    exp_rd_q.delete();
    for (int i = 0; i < NUM; i++) begin
      exp_wr_q.push_back('{addr: adr(i), data: pat(i)});
      exp_rd_q.push_back(adr(i));
      if (!withhold && bad_mask[i]) begin
        if (exp_err == 0) exp_first = adr(i);
        exp_err++;
      end
    end

    start = 1'b1;
    tick();
    start = 1'b0;
    check("wr_latency", 32'(bus.write_enable), 1);
    check("busy_run", 32'(busy), 1);
    check("done_clr", 32'(done), 0);

    for (int i = 0; i < NUM; i++) begin
      d = $urandom_range(0, 3);
      repeat (d) begin
        if (spur) begin
          bus.read_data_valid = 1'($urandom_range(0, 1));
          bus.data_from_ram   = DQ'($urandom);
          start               = 1'($urandom_range(0, 1));
        end
        tick();
      end
      if (pins) begin
        check("pin_wr_addr", 32'(bus.i_user_data_address), i);
        check("pin_wr_data", 32'(bus.data_to_ram), lit_data[i]);
      end
      bus.write_accepted = 1'b1;
      tick();
      bus.write_accepted  = 1'b0;
      bus.read_data_valid = 1'b0;
      start               = 1'b0;
    end
    check("wr_drop", 32'(bus.write_enable), 0);
    check("rd_latency", 32'(bus.read_enable), 1);

    if (withhold) begin
      cnt = 0;
      while (bus.read_enable && cnt < 100) begin
        cnt++;
        if (spur) bus.write_accepted = 1'($urandom_range(0, 1));
        tick();
      end
      bus.write_accepted = 1'b0;
      check("to_cycles", cnt, RTO);
      check("to_flag", 32'(timeout), 1);
      check("to_done", 32'(done), 1);
      check("to_pass", 32'(pass), 0);
      check("to_fea", 32'(first_error_address), 32'(adr(0)));
      check("to_ec", 32'(error_count), 0);
      check("to_busy", 32'(busy), 0);
    end else begin
      for (int i = 0; i < NUM; i++) begin
        d = $urandom_range(0, 6);
        repeat (d) begin
          if (spur) begin
            bus.write_accepted = 1'($urandom_range(0, 1));
            start              = 1'($urandom_range(0, 1));
          end
          tick();
        end
        rdata = pat(i);
        if (bad_mask[i]) rdata = fixed_bad ? DQ'(16'h00FF) : (pat(i) ^ DQ'($urandom_range(1, 65535)));
        bus.data_from_ram   = rdata;
        bus.read_data_valid = 1'b1;
        tick();
        bus.read_data_valid = 1'b0;
        bus.write_accepted  = 1'b0;
        start               = 1'b0;
      end
      check("done_latency", 32'(done), 1);
      check("done_busy", 32'(busy), 0);
      check("done_pass", 32'(pass), 32'(exp_err == 0));
      check("done_ec", 32'(error_count), exp_err);
      check("done_timeout", 32'(timeout), 0);
      if (exp_err != 0) check("done_fea", 32'(first_error_address), 32'(exp_first));
      check("wr_all_seen", exp_wr_q.size(), 0);
      check("rd_all_seen", exp_rd_q.size(), 0);
    end
    tick();
    check("done_hold", 32'(done), 1);
  endtask

  task automatic reset_mid_write();
    exp_wr_q.delete();
    exp_rd_q.delete();
    for (int i = 0; i < NUM; i++) exp_wr_q.push_back('{addr: adr(i), data: pat(i)});
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.write_accepted = 1'b1;
      tick();
      bus.write_accepted = 1'b0;
    end
    check("mid_addr", 32'(bus.i_user_data_address), 2);
    reset = 1'b1;
    tick();
    check("mid_rst_we", 32'(bus.write_enable), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_addr", 32'(bus.i_user_data_address), 0);
    reset = 1'b0;
    tick();
    check("mid_idle", 32'(busy), 0);
  endtask

  initial begin
    bus.write_accepted  = 1'b0;
    bus.read_data_valid = 1'b0;
    bus.data_from_ram   = '0;
    do_reset();

    run(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ideal_pass", 32'(pass), 1);
    check("ideal_ec", 32'(error_count), 0);

    run(4'b0100, 1'b0, 1'b0, 1'b1, 1'b0);
    check("corrupt_ec", 32'(error_count), 1);
    check("corrupt_fea", 32'(first_error_address), 2);
    check("corrupt_pass", 32'(pass), 0);

    run(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    check("timeout_fea", 32'(first_error_address), 0);

    reset_mid_write();
    run(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);

    for (int k = 0; k < 10; k++) begin
      run(NUM'($urandom_range(0, (1 << NUM) - 1)), 1'b0, 1'b1, 1'b0, 1'b0);
    end
    run(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
    run(4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
